// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan driver: segment bit order,
// glyph table and digit-count limit.
package seg_pkg;

  localparam int unsigned MAX_DIGITS = 8;
  localparam int unsigned SEG_W      = 8;

  // Bit position of each segment inside the active-low seg_n byte.
  typedef enum logic [2:0] {
    SEG_A, SEG_B, SEG_C, SEG_D, SEG_E, SEG_F, SEG_G, SEG_DP
  } seg_bit_e;

  localparam logic [SEG_W-1:0] SEG_BLANK   = 8'hFF;
  localparam logic [SEG_W-1:0] SEG_DP_ONLY = 8'h7F;

  // Glyphs for 0..F. Entries 10..15 are only shown in hex mode.
  localparam logic [SEG_W-1:0] SEG_GLYPH [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

endpackage

// File: rtl/seg_digit_encode.sv
// Combinational nibble-to-glyph encoder with decimal-point and blanking
// overrides for one common-anode digit.
module seg_digit_encode
  import seg_pkg::*;
(
  input  logic [3:0]       nibble,
  input  logic             hex_mode,
  input  logic             dp,
  input  logic             blank,
  output logic [SEG_W-1:0] seg_n
);

  // Later assignments take priority: invalid decimal, then blank, then DP.
  always_comb begin
    seg_n = SEG_GLYPH[nibble];
    if (!hex_mode && (nibble > 4'd9)) seg_n = SEG_DP_ONLY;
    if (blank) seg_n = SEG_BLANK;
    if (dp) seg_n[SEG_DP] = 1'b0;
  end

endmodule

// File: rtl/sev_seg_scan_driver.sv
// Time-multiplexed common-anode display driver: one digit per refresh period,
// new values are swapped in only at the frame boundary.
module sev_seg_scan_driver
  import seg_pkg::*;
#(
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp,
  input  logic                  hex_mode,
  input  logic                  blank_lz,
  output logic [SEG_W-1:0]      seg_n,
  output logic [DIGITS-1:0]     an_n,
  output logic                  frame_start,
  output logic                  update_pending
);

  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned VAL_W = 4 * DIGITS;

  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              tc, wrap;

  logic [VAL_W-1:0]  pend_value_q, act_value_q;
  logic [DIGITS-1:0] pend_dp_q, act_dp_q;
  logic              pend_hex_q, act_hex_q;
  logic              pend_blank_q, act_blank_q;

  logic [DIGITS-1:0] blank_mask;
  logic              zero_run;
  logic [3:0]        sel_nibble;
  logic              sel_dp, sel_blank;
  logic [SEG_W-1:0]  enc_seg;
  logic [DIGITS-1:0] an_sel;

  // Prescaler and scan index; wrap marks the frame boundary.
  always_comb begin
    tc    = (pre_q == PRE_W'(REFRESH_DIV - 1));
    wrap  = tc && (idx_q == IDX_W'(DIGITS - 1));
    pre_d = tc ? '0 : pre_q + PRE_W'(1);
    idx_d = idx_q;
    if (wrap)    idx_d = '0;
    else if (tc) idx_d = idx_q + IDX_W'(1);
  end

  // A digit above 0 blanks when it and every more significant nibble are zero.
  always_comb begin
    zero_run   = 1'b1;
    blank_mask = '0;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      zero_run      = zero_run && (act_value_q[4*i +: 4] == 4'd0);
      blank_mask[i] = act_blank_q && zero_run && (i != 0);
    end
  end

  always_comb begin
    sel_nibble = '0;
    sel_dp     = 1'b0;
    sel_blank  = 1'b0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (idx_q == IDX_W'(i)) begin
        sel_nibble = act_value_q[4*i +: 4];
        sel_dp     = act_dp_q[i];
        sel_blank  = blank_mask[i];
      end
    end
    an_sel = ~(DIGITS'(1) << idx_q);
  end

  seg_digit_encode u_encode (
    .nibble   (sel_nibble),
    .hex_mode (act_hex_q),
    .dp       (sel_dp),
    .blank    (sel_blank),
    .seg_n    (enc_seg)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q          <= '0;
      idx_q          <= '0;
      pend_value_q   <= '0;
      pend_dp_q      <= '0;
      pend_hex_q     <= 1'b0;
      pend_blank_q   <= 1'b0;
      act_value_q    <= '0;
      act_dp_q       <= '0;
      act_hex_q      <= 1'b0;
      act_blank_q    <= 1'b0;
      update_pending <= 1'b0;
      seg_n          <= SEG_BLANK;
      an_n           <= '1;
      frame_start    <= 1'b0;
    end else begin
      pre_q       <= pre_d;
      idx_q       <= idx_d;
      seg_n       <= enc_seg;
      an_n        <= an_sel;
      frame_start <= wrap;
      if (wrap) begin
        // Load on the boundary itself bypasses the pending stage.
        update_pending <= 1'b0;
        if (load) begin
          act_value_q <= value;
          act_dp_q    <= dp;
          act_hex_q   <= hex_mode;
          act_blank_q <= blank_lz;
        end else if (update_pending) begin
          act_value_q <= pend_value_q;
          act_dp_q    <= pend_dp_q;
          act_hex_q   <= pend_hex_q;
          act_blank_q <= pend_blank_q;
        end
      end else if (load) begin
        pend_value_q   <= value;
        pend_dp_q      <= dp;
        pend_hex_q     <= hex_mode;
        pend_blank_q   <= blank_lz;
        update_pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sev_seg_scan_driver.sv
// Scoreboard bench for sev_seg_scan_driver: expected digit presentations are
// queued by the stimulus and popped by a monitor on every an_n change.
module tb_sev_seg_scan_driver;

  localparam int unsigned DIGITS      = 4;
  localparam int unsigned REFRESH_DIV = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp;
  logic        hex_mode;
  logic        blank_lz;
  logic [7:0]  seg_n;
  logic [3:0]  an_n;
  logic        frame_start;
  logic        update_pending;

  always #5 clk = ~clk;

  sev_seg_scan_driver #(.DIGITS(DIGITS), .REFRESH_DIV(REFRESH_DIV)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .load           (load),
    .value          (value),
    .dp             (dp),
    .hex_mode       (hex_mode),
    .blank_lz       (blank_lz),
    .seg_n          (seg_n),
    .an_n           (an_n),
    .frame_start    (frame_start),
    .update_pending (update_pending)
  );

  typedef struct {
    logic [3:0] an;
    logic [7:0] seg;
    bit         chk_len;
    string      nm;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Queue one full frame, digit 0 first; g packs {d3,d2,d1,d0} glyphs.
  task automatic push_frame(input string nm, input logic [31:0] g, input bit len_first);
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      e.an      = ~(4'b0001 << i);
      e.seg     = g[8*i +: 8];
      e.chk_len = (i == 0) ? len_first : 1'b1;
      e.nm      = $sformatf("%s_d%0d", nm, i);
      sb.push_back(e);
    end
  endtask

  // Monitor: each new digit on an_n is one presented output.
  logic [3:0] prev_an = 4'hF;
  int         run = 0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_an = 4'hF;
      run     = 0;
    end else if (an_n !== prev_an) begin
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk({e.nm, "_an"}, 32'(an_n), 32'(e.an));
        chk({e.nm, "_seg"}, 32'(seg_n), 32'(e.seg));
        if (e.chk_len) chk({e.nm, "_prev_len"}, 32'(run), 32'(REFRESH_DIV));
      end
      prev_an = an_n;
      run     = 1;
    end else begin
      run++;
    end
  end

  task automatic wait_fs(input string nm);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_start && n < 100);
    chk({nm, "_fs_seen"}, 32'(frame_start), 32'd1);
  endtask

  task automatic wait_an(input logic [3:0] a, input string nm);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (an_n !== a && n < 50);
    chk(nm, 32'(an_n), 32'(a));
  endtask

  task automatic wait_sb_empty(input string nm);
    int n = 0;
    while (sb.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_drain"}, 32'(sb.size()), 32'd0);
  endtask

  // Called at a frame_start negedge; loads mid-frame and expects deferral.
  task automatic deferred(input string nm, input logic [15:0] v_first, input logic [15:0] v,
                          input logic [3:0] d, input logic hx, input logic bl,
                          input logic [31:0] old_g, input logic [31:0] new_g);
    push_frame({nm, "_old"}, old_g, 1'b1);
    push_frame({nm, "_new"}, new_g, 1'b1);
    load = 1'b1; value = v_first; dp = d; hex_mode = hx; blank_lz = bl;
    if (v_first !== v) begin
      @(negedge clk);
      value = v;
    end
    @(negedge clk);
    load = 1'b0;
    chk({nm, "_pending_set"}, 32'(update_pending), 32'd1);
    wait_fs(nm);
    chk({nm, "_pending_clr"}, 32'(update_pending), 32'd0);
    wait_sb_empty(nm);
    wait_fs({nm, "_next"});
  endtask

  // Called at a frame_start negedge; loads exactly on the next wrap edge.
  task automatic wrap_load(input string nm, input logic [15:0] v, input logic [3:0] d,
                           input logic hx, input logic bl,
                           input logic [31:0] old_g, input logic [31:0] new_g);
    push_frame({nm, "_old"}, old_g, 1'b1);
    push_frame({nm, "_new"}, new_g, 1'b1);
    repeat (DIGITS * REFRESH_DIV - 1) @(negedge clk);
    load = 1'b1; value = v; dp = d; hex_mode = hx; blank_lz = bl;
    @(negedge clk);
    load = 1'b0;
    chk({nm, "_on_wrap"}, 32'(frame_start), 32'd1);
    chk({nm, "_no_pending"}, 32'(update_pending), 32'd0);
    wait_sb_empty(nm);
    wait_fs({nm, "_next"});
  endtask

  initial begin
    int c1;
    rst_n = 1'b0; load = 1'b0; value = '0; dp = '0; hex_mode = 1'b0; blank_lz = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_seg", 32'(seg_n), 32'hFF);
    chk("rst_an", 32'(an_n), 32'hF);
    chk("rst_fs", 32'(frame_start), 32'd0);
    chk("rst_pending", 32'(update_pending), 32'd0);

    push_frame("scan0", 32'hC0C0C0C0, 1'b0);
    push_frame("scan1", 32'hC0C0C0C0, 1'b1);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("first_an", 32'(an_n), 32'hE);
    chk("first_seg", 32'(seg_n), 32'hC0);

    wait_fs("scan");
    c1 = cyc;
    @(negedge clk);
    chk("fs_width", 32'(frame_start), 32'd0);
    wait_fs("scan2");
    chk("fs_period", 32'(cyc - c1), 32'd16);
    wait_sb_empty("scan");

    deferred("dec", 16'h90AF, 16'h90AF, 4'b0000, 1'b0, 1'b0, 32'hC0C0C0C0, 32'h90C07F7F);
    deferred("hex", 16'h90AF, 16'h90AF, 4'b0000, 1'b1, 1'b0, 32'h90C07F7F, 32'h90C0888E);
    wrap_load("blank", 16'h0042, 4'b0100, 1'b0, 1'b1, 32'h90C0888E, 32'hFF7F99A4);
    deferred("noblank", 16'h0042, 16'h0042, 4'b0100, 1'b0, 1'b0, 32'hFF7F99A4, 32'hC04099A4);
    deferred("lastwins", 16'h1234, 16'h5678, 4'b0000, 1'b0, 1'b0, 32'hC04099A4, 32'h9282F880);

    // Mid-frame reset with an update waiting: outputs drop immediately, update lost.
    wait_an(4'b1101, "rstmid_d1");
    load = 1'b1; value = 16'h8888; dp = 4'b1111; hex_mode = 1'b0; blank_lz = 1'b0;
    @(negedge clk);
    load = 1'b0;
    chk("rstmid_pending_set", 32'(update_pending), 32'd1);
    wait_an(4'b1011, "rstmid_d2");
    #3 rst_n = 1'b0;
    #1;
    chk("rstmid_seg", 32'(seg_n), 32'hFF);
    chk("rstmid_an", 32'(an_n), 32'hF);
    chk("rstmid_fs", 32'(frame_start), 32'd0);
    chk("rstmid_pending", 32'(update_pending), 32'd0);
    @(negedge clk);
    push_frame("post_rst0", 32'hC0C0C0C0, 1'b0);
    push_frame("post_rst1", 32'hC0C0C0C0, 1'b1);
    @(negedge clk);
    #2 rst_n = 1'b1;
    wait_sb_empty("post_rst");
    chk("post_rst_pending", 32'(update_pending), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
